// File: rtl/rbz_pkg.sv
// Shared definitions for the rbzero SPI loader: FSM encoding, grant IDs and
// default payload sizes.
package rbz_pkg;

  localparam int DEF_VEC_BITS = 74;
  localparam int DEF_REG_BITS = 14;
  localparam int ST_W         = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  typedef enum logic {
    GNT_VEC = 1'b0,
    GNT_REG = 1'b1
  } gnt_e;

  function automatic int rbz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rbz_spi_tx_engine.sv
// Mode-0 SPI serializer: shifts out i_len bits of a left-aligned word, MSB
// first, framed by SETUP / HIGH / LOW / GAP phases of CLK_DIV cycles each.
module rbz_spi_tx_engine
  import rbz_pkg::*;
#(
  parameter int W       = 74,
  parameter int BCW     = 7,
  parameter int CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_start,
  input  logic [BCW-1:0] i_len,
  input  logic [W-1:0]   i_data,
  output logic           o_done,
  output logic           o_busy,
  output logic           o_csb,
  output logic           o_sclk,
  output logic           o_mosi
);

  localparam int             PCW     = $clog2(CLK_DIV + 1);
  localparam logic [PCW-1:0] PH_LOAD = PCW'(CLK_DIV - 1);

  state_e         r_state;
  logic [W-1:0]   r_shift;
  logic [BCW-1:0] r_bits;
  logic [PCW-1:0] r_ph;
  logic           r_csb;
  logic           r_sclk;
  logic           r_mosi;
  logic           r_busy;
  logic           r_done;
  logic           w_ph_end;

  assign w_ph_end = (r_ph == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bits  <= '0;
      r_ph    <= '0;
      r_csb   <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SETUP;
            r_shift <= i_data;
            r_bits  <= i_len;
            r_ph    <= PH_LOAD;
            r_csb   <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= i_data[W-1];
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_ph_end) begin
            r_state <= ST_HIGH;
            r_sclk  <= 1'b1;
            r_ph    <= PH_LOAD;
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        ST_HIGH: begin
          // Next bit is presented on the falling edge so MOSI never moves while SCLK is high.
          if (w_ph_end) begin
            r_state <= ST_LOW;
            r_sclk  <= 1'b0;
            r_bits  <= r_bits - 1'b1;
            r_shift <= r_shift << 1;
            r_mosi  <= r_shift[W-2];
            r_ph    <= PH_LOAD;
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        ST_LOW: begin
          if (w_ph_end) begin
            r_ph <= PH_LOAD;
            if (r_bits == '0) begin
              r_state <= ST_GAP;
              r_csb   <= 1'b1;
              r_mosi  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_HIGH;
              r_sclk  <= 1'b1;
            end
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        ST_GAP: begin
          if (w_ph_end) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_done = r_done;
  assign o_busy = r_busy;
  assign o_csb  = r_csb;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;

endmodule

// File: rtl/rbz_spi_loader.sv
// Round-robin front end that feeds rbzero's vector and register SPI slaves from
// parallel write requests through one shared serializer.
module rbz_spi_loader
  import rbz_pkg::*;
#(
  parameter int VEC_BITS = DEF_VEC_BITS,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int CLK_DIV  = 2,
  parameter int GATE_VEC = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vblank,
  input  logic                vec_req,
  input  logic [VEC_BITS-1:0] vec_data,
  output logic                vec_ack,
  input  logic                reg_req,
  input  logic [REG_BITS-1:0] reg_data,
  output logic                reg_ack,
  output logic                busy,
  output logic                vec_csb,
  output logic                vec_sclk,
  output logic                vec_mosi,
  output logic                reg_csb,
  output logic                reg_sclk,
  output logic                reg_mosi
);

  localparam int W   = rbz_max(VEC_BITS, REG_BITS);
  localparam int BCW = $clog2(W + 1);

  gnt_e           r_gnt;
  gnt_e           r_last;
  logic           r_vec_ack;
  logic           r_reg_ack;
  logic           w_vec_ok;
  logic           w_reg_ok;
  logic           w_start;
  gnt_e           w_pick;
  logic [BCW-1:0] w_len;
  logic [W-1:0]   w_data;
  logic           w_done;
  logic           w_busy;
  logic           w_csb;
  logic           w_sclk;
  logic           w_mosi;

  assign w_vec_ok = vec_req && ((GATE_VEC == 0) || vblank);
  assign w_reg_ok = reg_req;
  assign w_start  = !w_busy && (w_vec_ok || w_reg_ok);

  always_comb begin
    w_pick = GNT_VEC;
    if (w_vec_ok && w_reg_ok) begin
      w_pick = (r_last == GNT_VEC) ? GNT_REG : GNT_VEC;
    end else if (w_reg_ok) begin
      w_pick = GNT_REG;
    end
  end

  assign w_len  = (w_pick == GNT_REG) ? BCW'(REG_BITS) : BCW'(VEC_BITS);
  assign w_data = (w_pick == GNT_REG) ? (W'(reg_data) << (W - REG_BITS))
                                      : (W'(vec_data) << (W - VEC_BITS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt     <= GNT_VEC;
      r_last    <= GNT_VEC;
      r_vec_ack <= 1'b0;
      r_reg_ack <= 1'b0;
    end else begin
      r_vec_ack <= w_start && (w_pick == GNT_VEC);
      r_reg_ack <= w_start && (w_pick == GNT_REG);
      if (w_start) r_gnt <= w_pick;
      // Updated while the engine sits in GAP so the next IDLE arbitration sees it.
      if (w_done) r_last <= r_gnt;
    end
  end

  rbz_spi_tx_engine #(
    .W       (W),
    .BCW     (BCW),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_len   (w_len),
    .i_data  (w_data),
    .o_done  (w_done),
    .o_busy  (w_busy),
    .o_csb   (w_csb),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi)
  );

  // Steering is a mux of registers only; the grant cannot change while the engine is active.
  assign vec_csb  = (r_gnt == GNT_VEC) ? w_csb  : 1'b1;
  assign vec_sclk = (r_gnt == GNT_VEC) ? w_sclk : 1'b0;
  assign vec_mosi = (r_gnt == GNT_VEC) ? w_mosi : 1'b0;
  assign reg_csb  = (r_gnt == GNT_REG) ? w_csb  : 1'b1;
  assign reg_sclk = (r_gnt == GNT_REG) ? w_sclk : 1'b0;
  assign reg_mosi = (r_gnt == GNT_REG) ? w_mosi : 1'b0;
  assign vec_ack  = r_vec_ack;
  assign reg_ack  = r_reg_ack;
  assign busy     = w_busy;

endmodule
